pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Sequences one instruction at a time through the stages
//            IF -> ID -> EX -> MEM -> WB. It handles an optional second MEM
//            cycle, EX-stage flushes, a HALT state, and an optional MEM
//            wait-state mechanism with a timeout.
// Revision : 1.0 - initial release
//
// Build option:
//   SEQ_WAIT_STATES_EN - when defined, mem_ready stretches MEM cycles and a
//                        wait counter forces completion after WAIT_TIMEOUT
//                        consecutive wait cycles. bus_error pulses when that
//                        happens. When undefined, every MEM cycle takes one
//                        clock and bus_error is tied low.
//
// Ports:
//   clk            in   single clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   mem_two_cycle  in   instruction needs two MEM cycles (held per instr)
//   mem_ready      in   data memory completes the current MEM cycle
//   flush          in   taken control transfer resolved in EX
//   halt_req       in   stop after the current instruction
//   pipeline_stage out  current stage code (STAGE_IF while halted)
//   cycle_count    out  MEM sub-cycle index (0/1), 0 outside MEM
//   instr_done     out  one-cycle pulse after an instruction retires
//   instr_count    out  retired-instruction count (wraps)
//   halted         out  sequencer is in HALT
//   bus_error      out  one-cycle pulse after a MEM wait timeout
// ============================================================================
`default_nettype none

`ifndef STAGE_COUNT
`define STAGE_COUNT 3
`endif
`ifndef STAGE_IF
`define STAGE_IF  3'd0
`define STAGE_ID  3'd1
`define STAGE_EX  3'd2
`define STAGE_MEM 3'd3
`define STAGE_WB  3'd4
`endif

module pipeline_sequencer #(
    parameter int INSTR_CNT_W  = 16,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_two_cycle,
    input  logic                     mem_ready,
    input  logic                     flush,
    input  logic                     halt_req,
    output logic [`STAGE_COUNT-1:0]  pipeline_stage,
    output logic                     cycle_count,
    output logic                     instr_done,
    output logic [INSTR_CNT_W-1:0]   instr_count,
    output logic                     halted,
    output logic                     bus_error
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic                   cc_q, cc_d;
    logic                   done_q, done_d;
    logic [INSTR_CNT_W-1:0] count_q;
    logic                   mem_done;

`ifdef SEQ_WAIT_STATES_EN
    logic [7:0] wait_q, wait_d;
    logic       timeout;
    logic       berr_q;

    // The WAIT_TIMEOUT-th consecutive wait cycle is itself treated as the
    // completing cycle, so MEM never lasts more than WAIT_TIMEOUT clocks.
    assign timeout  = (state_q == ST_MEM) && !mem_ready &&
                      (wait_q == 8'(WAIT_TIMEOUT - 1));
    assign mem_done = mem_ready || timeout;

    always_comb begin
        wait_d = '0;
        if (state_q == ST_MEM && !mem_done) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            berr_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            berr_q <= timeout;
        end
    end

    assign bus_error = berr_q;
`else
    logic w_unused_mem_ready;

    assign w_unused_mem_ready = mem_ready;
    assign mem_done           = 1'b1;
    assign bus_error          = 1'b0;
`endif

    // Next-state and retirement detection
    always_comb begin
        state_d = state_q;
        cc_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                if (flush) begin
                    done_d  = 1'b1;
                    state_d = halt_req ? ST_HALT : ST_IF;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                cc_d = cc_q;
                if (mem_done) begin
                    if (!cc_q && mem_two_cycle) begin
                        cc_d = 1'b1;
                    end else begin
                        cc_d    = 1'b0;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                done_d  = 1'b1;
                state_d = halt_req ? ST_HALT : ST_IF;
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_d = ST_IF;
                end
            end
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IF;
            cc_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            done_q  <= done_d;
            // Count advances on the same edge that raises instr_done.
            if (done_d) begin
                count_q <= count_q + {{(INSTR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        pipeline_stage = `STAGE_IF;
        case (state_q)
            ST_ID:   pipeline_stage = `STAGE_ID;
            ST_EX:   pipeline_stage = `STAGE_EX;
            ST_MEM:  pipeline_stage = `STAGE_MEM;
            ST_WB:   pipeline_stage = `STAGE_WB;
            default: pipeline_stage = `STAGE_IF;
        endcase
    end

    assign cycle_count = cc_q;
    assign instr_done  = done_q;
    assign instr_count = count_q;
    assign halted      = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Self-checking bench for pipeline_sequencer. Directed scenarios
//            cover reset, the basic and two-cycle flows, flush, halt, wait
//            states and asynchronous reset. A randomized instruction stream
//            is checked against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

    localparam int       TO    = 15;
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_two_cycle = 1'b0;
    logic        mem_ready = 1'b1;
    logic        flush = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  stage;
    logic        cc, done, halted, berr;
    logic [15:0] count;
    logic [2:0]  stage_w_unused;
    logic        cc_w_unused, done_w_unused, halted_w_unused, berr_w_unused;
    logic [1:0]  count_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.INSTR_CNT_W(16), .WAIT_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_two_cycle(mem_two_cycle),
        .mem_ready(mem_ready), .flush(flush), .halt_req(halt_req),
        .pipeline_stage(stage), .cycle_count(cc), .instr_done(done),
        .instr_count(count), .halted(halted), .bus_error(berr)
    );

    // Narrow counter instance, used to observe the wrap from all-ones to 0.
    pipeline_sequencer #(.INSTR_CNT_W(2), .WAIT_TIMEOUT(TO)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .mem_two_cycle(mem_two_cycle),
        .mem_ready(mem_ready), .flush(flush), .halt_req(halt_req),
        .pipeline_stage(stage_w_unused), .cycle_count(cc_w_unused),
        .instr_done(done_w_unused), .instr_count(count_w),
        .halted(halted_w_unused), .bus_error(berr_w_unused)
    );

    // One expected cycle: outputs seen during it, inputs driven in it, and
    // whether it ends an instruction / times out (visible next cycle).
    typedef struct {
        logic [2:0] stg;
        logic       cc, hlt, two, rdy, fl, hr, dn, be;
    } cyc_t;
    cyc_t q[$];

    task automatic step(input logic two, input logic rdy, input logic fl, input logic hr);
        mem_two_cycle = two; mem_ready = rdy; flush = fl; halt_req = hr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [2:0] stg, input logic c, input logic h,
                        input logic two, input logic rdy, input logic fl,
                        input logic hr, input logic dn, input logic be);
        cyc_t r;
        r.stg = stg; r.cc = c; r.hlt = h; r.two = two; r.rdy = rdy;
        r.fl = fl; r.hr = hr; r.dn = dn; r.be = be;
        q.push_back(r);
    endtask

    // Expands one instruction into the cycles it must take.
    task automatic gen_instr(input logic two, input logic fl, input logic hlt,
                             input int hcyc, input int w0, input int w1);
        int w;
        logic rb;
        push(S_IF, 0, 0, two, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        push(S_ID, 0, 0, two, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        if (fl) begin
            push(S_EX, 0, 0, two, 1'($urandom), 1, hlt, 1, 0);
        end else begin
            push(S_EX, 0, 0, two, 1'($urandom), 0, 1'($urandom), 0, 0);
            for (int s = 0; s < (two ? 2 : 1); s++) begin
                w = (s == 0) ? w0 : w1;
`ifdef SEQ_WAIT_STATES_EN
                if (w >= TO) begin
                    for (int i = 0; i < TO - 1; i++)
                        push(S_MEM, 1'(s), 0, two, 0, 1'($urandom), 1'($urandom), 0, 0);
                    push(S_MEM, 1'(s), 0, two, 0, 1'($urandom), 1'($urandom), 0, 1);
                end else begin
                    for (int i = 0; i < w; i++)
                        push(S_MEM, 1'(s), 0, two, 0, 1'($urandom), 1'($urandom), 0, 0);
                    push(S_MEM, 1'(s), 0, two, 1, 1'($urandom), 1'($urandom), 0, 0);
                end
`else
                rb = 1'($urandom);
                push(S_MEM, 1'(s), 0, two, rb, 1'($urandom), 1'($urandom), 0, 0);
`endif
            end
            push(S_WB, 0, 0, two, 1'($urandom), 1'($urandom), hlt, 1, 0);
        end
        if (hlt) begin
            for (int i = 0; i < hcyc; i++)
                push(S_IF, 0, 1, two, 1'($urandom), 1'($urandom), (i < hcyc - 1), 0, 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        n_checks++; if (stage !== S_IF || cc !== 1'b0 || done !== 1'b0 || halted !== 1'b0 || berr !== 1'b0) $display("FAIL reset_outputs stage=%0d cc=%b done=%b halted=%b berr=%b, want 0/0/0/0/0", stage, cc, done, halted, berr); else n_pass++;
        n_checks++; if (count !== 16'd0) $display("FAIL reset_count got=%0d want=0", count); else n_pass++;
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        n_checks++; if (stage !== S_ID) $display("FAIL reset_first_edge got=%0d want=%0d", stage, S_ID); else n_pass++;
    endtask

    task automatic test_basic();
        logic [2:0] pat [5];
        pat[0] = S_IF; pat[1] = S_ID; pat[2] = S_EX; pat[3] = S_MEM; pat[4] = S_WB;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 0, 0);
            n_checks++; if (stage !== pat[k % 5] || cc !== 1'b0) $display("FAIL basic_stage k=%0d got=%0d/%b want=%0d/0", k, stage, cc, pat[k % 5]); else n_pass++;
            n_checks++; if (done !== (k % 5 == 0)) $display("FAIL basic_done k=%0d got=%b want=%b", k, done, (k % 5 == 0)); else n_pass++;
        end
        n_checks++; if (count !== 16'd4) $display("FAIL basic_count got=%0d want=4", count); else n_pass++;
        n_checks++; if (count_w !== 2'd0) $display("FAIL count_wrap got=%0d want=0", count_w); else n_pass++;
    endtask

    task automatic test_two_cycle();
        logic [2:0] pat [6];
        pat[0] = S_IF; pat[1] = S_ID; pat[2] = S_EX; pat[3] = S_MEM; pat[4] = S_MEM; pat[5] = S_WB;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, 0, 0);
            n_checks++; if (stage !== pat[k % 6] || cc !== (k % 6 == 4)) $display("FAIL two_cycle k=%0d got=%0d/%b want=%0d/%b", k, stage, cc, pat[k % 6], (k % 6 == 4)); else n_pass++;
        end
        n_checks++; if (count !== 16'd2) $display("FAIL two_cycle_count got=%0d want=2", count); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        n_checks++; if (stage !== S_EX) $display("FAIL flush_in_id got=%0d want=%0d", stage, S_EX); else n_pass++;
        step(0, 1, 1, 0);
        n_checks++; if (stage !== S_IF || done !== 1'b1 || count !== 16'd1) $display("FAIL flush_in_ex stage=%0d done=%b count=%0d want %0d/1/1", stage, done, count, S_IF); else n_pass++;
        step(0, 1, 0, 0);
        n_checks++; if (stage !== S_ID || done !== 1'b0) $display("FAIL flush_pulse stage=%0d done=%b want %0d/0", stage, done, S_ID); else n_pass++;
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        n_checks++; if (halted !== 1'b1 || stage !== S_IF || done !== 1'b1 || count !== 16'd2) $display("FAIL flush_halt halted=%b stage=%0d done=%b count=%0d want 1/0/1/2", halted, stage, done, count); else n_pass++;
        step(0, 1, 0, 0);
        n_checks++; if (halted !== 1'b0 || stage !== S_IF) $display("FAIL flush_unhalt halted=%b stage=%0d want 0/0", halted, stage); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        n_checks++; if (stage !== S_WB || halted !== 1'b0) $display("FAIL halt_finishes stage=%0d halted=%b want %0d/0", stage, halted, S_WB); else n_pass++;
        step(0, 1, 0, 1);
        n_checks++; if (halted !== 1'b1 || stage !== S_IF || done !== 1'b1 || count !== 16'd1) $display("FAIL halt_enter halted=%b stage=%0d done=%b count=%0d want 1/0/1/1", halted, stage, done, count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1);
            n_checks++; if (halted !== 1'b1 || done !== 1'b0) $display("FAIL halt_hold i=%0d halted=%b done=%b want 1/0", i, halted, done); else n_pass++;
        end
        step(0, 1, 0, 0);
        n_checks++; if (halted !== 1'b0 || stage !== S_IF) $display("FAIL halt_release halted=%b stage=%0d want 0/0", halted, stage); else n_pass++;
        step(0, 1, 0, 0);
        n_checks++; if (stage !== S_ID) $display("FAIL halt_resume got=%0d want=%0d", stage, S_ID); else n_pass++;
    endtask

    task automatic test_wait_states();
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
`ifdef SEQ_WAIT_STATES_EN
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            n_checks++; if (stage !== S_MEM) $display("FAIL wait_hold i=%0d got=%0d want=%0d", i, stage, S_MEM); else n_pass++;
        end
        step(0, 1, 0, 0);
        n_checks++; if (stage !== S_WB || berr !== 1'b0) $display("FAIL wait_release stage=%0d berr=%b want %0d/0", stage, berr, S_WB); else n_pass++;
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            step(0, 0, 0, 0);
            n_checks++; if (stage !== ((i == TO) ? S_WB : S_MEM) || berr !== (i == TO)) $display("FAIL timeout i=%0d stage=%0d berr=%b want %0d/%b", i, stage, berr, ((i == TO) ? S_WB : S_MEM), (i == TO)); else n_pass++;
        end
        step(0, 0, 0, 0);
        n_checks++; if (stage !== S_IF || berr !== 1'b0) $display("FAIL timeout_pulse stage=%0d berr=%b want 0/0", stage, berr); else n_pass++;
`else
        step(0, 0, 0, 0);
        n_checks++; if (stage !== S_WB || berr !== 1'b0) $display("FAIL ready_ignored stage=%0d berr=%b want %0d/0", stage, berr, S_WB); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        n_checks++; if (stage !== S_MEM || cc !== 1'b1 || count !== 16'd1) $display("FAIL pre_reset stage=%0d cc=%b count=%0d want %0d/1/1", stage, cc, count, S_MEM); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (stage !== S_IF || cc !== 1'b0 || count !== 16'd0 || done !== 1'b0) $display("FAIL reset_mid_mem stage=%0d cc=%b count=%0d done=%b want 0/0/0/0", stage, cc, count, done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        n_checks++; if (halted !== 1'b1) $display("FAIL pre_reset_halt got=%b want=1", halted); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0 || stage !== S_IF || count !== 16'd0) $display("FAIL reset_in_halt halted=%b stage=%0d count=%0d want 0/0/0", halted, stage, count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        e_done, e_berr;
        logic [15:0] e_cnt;
        int          w0, w1, r;
        int          shown;
        q.delete();
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom % 8);
            w0 = (r < 4) ? 0 : (r < 7) ? int'(1 + $urandom % 4) : int'(TO + $urandom % 3);
            r = int'($urandom % 8);
            w1 = (r < 4) ? 0 : (r < 7) ? int'(1 + $urandom % 4) : int'(TO + $urandom % 3);
            gen_instr(1'($urandom), ($urandom % 4 == 0), ($urandom % 5 == 0),
                      int'(1 + $urandom % 3), w0, w1);
        end
        push(S_IF, 0, 0, 0, 1, 0, 0, 0, 0);
        do_reset();
        e_done = 1'b0; e_berr = 1'b0; e_cnt = 16'd0; shown = 0;
        for (int t = 0; t < q.size(); t++) begin
            n_checks++;
            if (stage !== q[t].stg || cc !== q[t].cc || halted !== q[t].hlt) begin
                if (shown < 20) $display("FAIL rand_state t=%0d stage/cc/halted=%0d/%b/%b want %0d/%b/%b", t, stage, cc, halted, q[t].stg, q[t].cc, q[t].hlt);
                shown++;
            end else n_pass++;
            n_checks++;
            if (done !== e_done || berr !== e_berr || count !== e_cnt) begin
                if (shown < 20) $display("FAIL rand_pulse t=%0d done/berr/count=%b/%b/%0d want %b/%b/%0d", t, done, berr, count, e_done, e_berr, e_cnt);
                shown++;
            end else n_pass++;
            step(q[t].two, q[t].rdy, q[t].fl, q[t].hr);
            e_done = q[t].dn;
            e_berr = q[t].be;
            if (e_done) e_cnt = e_cnt + 16'd1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_two_cycle();
        test_flush();
        test_halt();
        test_wait_states();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
